// File: rtl/access_ctrl_scan.sv
// access_ctrl_scan
//   Password access controller. An enter pulse latches the typed password,
//   then every entry of an external synchronous password memory is read and
//   compared with it. The lowest matching index is reported with granted;
//   a full scan without a match pulses denied. MAX_FAILS consecutive misses
//   lock the block for LOCK_CYCLES clocks.
//
// Ports
//   clk        system clock, rising edge
//   clr_n      asynchronous active-low reset
//   enter      single-cycle enter pulse (already synchronised)
//   senha      typed password
//   mem_addr   password memory address
//   mem_data   memory read data, valid MEM_LAT cycles after mem_addr
//   busy       scan in progress
//   granted    level, last attempt matched
//   denied     one-cycle pulse, last attempt failed
//   locked     level, lockout active
//   match_idx  index of the matching entry, valid while granted
//   fail_cnt   consecutive failure count
//
// state | meaning
// IDLE  | waiting for enter
// SCAN  | issuing addresses 0..DEPTH-1, comparing returning words
// DRAIN | all addresses issued, comparing the last MEM_LAT words
// LOCK  | lockout timer running, enter ignored
module access_ctrl_scan #(
  parameter int PW_WIDTH    = 8,
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int MEM_LAT     = 1,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 1000,
  parameter int CNT_W       = 10,
  localparam int FC_W       = $clog2(MAX_FAILS + 1)
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                enter,
  input  logic [PW_WIDTH-1:0] senha,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [PW_WIDTH-1:0] mem_data,
  output logic                busy,
  output logic                granted,
  output logic                denied,
  output logic                locked,
  output logic [ADDR_W-1:0]   match_idx,
  output logic [FC_W-1:0]     fail_cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, LOCK} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [FC_W-1:0]   FAIL_MAX  = FC_W'(MAX_FAILS);
  localparam logic [CNT_W-1:0]  LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);

  state_t                state_q, state_nxt;
  logic [PW_WIDTH-1:0]   pw_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [CNT_W-1:0]      timer_q;
  logic                  granted_q, denied_q;
  logic [ADDR_W-1:0]     match_q;
  logic [FC_W-1:0]       fail_q;

  // Delay line tagging each outstanding read with the address it came from.
  logic [MEM_LAT-1:0]    vld_q;
  logic [ADDR_W-1:0]     tag_q [MEM_LAT];

  logic                  scanning, accept, word_ok, hit, miss, lock_go;
  logic [FC_W-1:0]       fail_inc;

  assign scanning = (state_q == SCAN) || (state_q == DRAIN);
  assign accept   = (state_q == IDLE) && enter;
  assign word_ok  = scanning && vld_q[MEM_LAT-1];
  assign hit      = word_ok && (mem_data == pw_q);
  // The last address's word is the final one; no match there means a miss.
  assign miss     = word_ok && (mem_data != pw_q) && (state_q == DRAIN)
                    && (tag_q[MEM_LAT-1] == LAST_ADDR);
  assign fail_inc = (fail_q == FAIL_MAX) ? fail_q : fail_q + FC_W'(1);
  assign lock_go  = miss && (fail_inc == FAIL_MAX);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:  if (enter) state_nxt = SCAN;
      SCAN: begin
        if (hit)                       state_nxt = IDLE;
        else if (addr_q == LAST_ADDR)  state_nxt = DRAIN;
      end
      DRAIN: begin
        if (hit)          state_nxt = IDLE;
        else if (lock_go) state_nxt = LOCK;
        else if (miss)    state_nxt = IDLE;
      end
      LOCK:  if (timer_q == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pw_q      <= '0;
      addr_q    <= '0;
      timer_q   <= '0;
      granted_q <= 1'b0;
      denied_q  <= 1'b0;
      match_q   <= '0;
      fail_q    <= '0;
      vld_q     <= '0;
      for (int i = 0; i < MEM_LAT; i++) tag_q[i] <= '0;
    end else begin
      denied_q <= miss;

      if (accept) begin
        pw_q      <= senha;
        addr_q    <= '0;
        granted_q <= 1'b0;
      end else if (state_q == SCAN && addr_q != LAST_ADDR) begin
        addr_q <= addr_q + ADDR_W'(1);
      end

      // Flush on a result so stale words never reach the next attempt.
      if (hit || miss) begin
        vld_q <= '0;
      end else begin
        for (int i = MEM_LAT - 1; i > 0; i--) begin
          vld_q[i] <= vld_q[i-1];
          tag_q[i] <= tag_q[i-1];
        end
        vld_q[0] <= (state_q == SCAN);
        tag_q[0] <= addr_q;
      end

      if (hit) begin
        granted_q <= 1'b1;
        match_q   <= tag_q[MEM_LAT-1];
        fail_q    <= '0;
      end else if (miss) begin
        fail_q <= fail_inc;
      end

      if (lock_go) begin
        timer_q <= LOCK_LOAD;
      end else if (state_q == LOCK) begin
        if (timer_q == '0) fail_q  <= '0;
        else               timer_q <= timer_q - CNT_W'(1);
      end
    end
  end

  assign mem_addr  = addr_q;
  assign busy      = scanning;
  assign granted   = granted_q;
  assign denied    = denied_q;
  assign locked    = (state_q == LOCK);
  assign match_idx = match_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_access_ctrl_scan.sv
// Directed bench for access_ctrl_scan: DEPTH=32, MEM_LAT=1, MAX_FAILS=3,
// LOCK_CYCLES=20, registered ROM model.
module tb_access_ctrl_scan;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       enter = 1'b0;
  logic [7:0] senha = '0;
  logic [4:0] mem_addr;
  logic [7:0] mem_data = '0;
  logic       busy, granted, denied, locked;
  logic [4:0] match_idx;
  logic [1:0] fail_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0] rom [32];

  access_ctrl_scan #(
    .PW_WIDTH(8), .DEPTH(32), .ADDR_W(5), .MEM_LAT(1),
    .MAX_FAILS(3), .LOCK_CYCLES(20), .CNT_W(10)
  ) dut (
    .clk(clk), .clr_n(clr_n), .enter(enter), .senha(senha),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy),
    .granted(granted), .denied(denied), .locked(locked),
    .match_idx(match_idx), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= rom[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse enter with pw in cycle E and wait for the result.
  // lat is N where the result is first seen in cycle E+N.
  task automatic attempt(input logic [7:0] pw, output int lat);
    @(negedge clk);
    enter = 1'b1;
    senha = pw;
    @(negedge clk);
    enter = 1'b0;
    senha = 8'hEE;
    lat = 1;
    check("busy_e1", {31'd0, busy}, 32'd1);
    check("addr_e1", {27'd0, mem_addr}, 32'd0);
    while (!(granted || denied) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("no_timeout", {31'd0, lat < 200}, 32'd1);
    check("g_and_d", {31'd0, granted & denied}, 32'd0);
  endtask

  int lat;
  int cnt;

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 8'h10 + 8'(i);
    rom[5]  = 8'hA5;
    rom[31] = 8'h3C;
    rom[9]  = 8'h77;
    rom[20] = 8'h77;

    #1;
    check("rst_outs", {busy, granted, denied, locked, mem_addr, match_idx, fail_cnt}, 32'd0);
    repeat (3) @(negedge clk);
    clr_n = 1'b1;

    // 1: A5 at index 5
    attempt(8'hA5, lat);
    check("t1_lat", lat, 8);
    check("t1_grant", {31'd0, granted}, 32'd1);
    check("t1_idx", {27'd0, match_idx}, 32'd5);
    check("t1_fail", {30'd0, fail_cnt}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t1_hold", {31'd0, granted}, 32'd1);

    // 2: last entry
    attempt(8'h3C, lat);
    check("t2_lat", lat, 34);
    check("t2_idx", {27'd0, match_idx}, 32'd31);

    // 3: duplicate, lowest index wins
    attempt(8'h77, lat);
    check("t3_lat", lat, 12);
    check("t3_idx", {27'd0, match_idx}, 32'd9);

    // 4: three misses, lockout
    for (int k = 1; k <= 3; k++) begin
      attempt(8'h00, lat);
      check("t4_lat", lat, 34);
      check("t4_denied", {31'd0, denied}, 32'd1);
      check("t4_grant", {31'd0, granted}, 32'd0);
      check("t4_fail", {30'd0, fail_cnt}, k);
      check("t4_locked", {31'd0, locked}, (k == 3) ? 32'd1 : 32'd0);
    end
    cnt = 0;
    while (locked && cnt < 100) begin
      cnt++;
      enter = (cnt == 5 || cnt == 19);
      senha = 8'hA5;
      @(negedge clk);
    end
    enter = 1'b0;
    check("t4_lock_len", cnt, 20);
    check("t4_fail_clr", {30'd0, fail_cnt}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_no_grant", {31'd0, granted}, 32'd0);
    attempt(8'hA5, lat);
    check("t4_after", {31'd0, granted}, 32'd1);
    check("t4_after_idx", {27'd0, match_idx}, 32'd5);

    // 5: two misses, then hit clears count, then single miss
    attempt(8'h01, lat);
    attempt(8'h02, lat);
    check("t5_fail2", {30'd0, fail_cnt}, 32'd2);
    attempt(8'hA5, lat);
    check("t5_grant", {31'd0, granted}, 32'd1);
    check("t5_fail0", {30'd0, fail_cnt}, 32'd0);
    attempt(8'h03, lat);
    check("t5_fail1", {30'd0, fail_cnt}, 32'd1);
    @(negedge clk);
    check("t5_nolock", {31'd0, locked}, 32'd0);

    // 6: ignored enter mid-scan, then reset during scan
    @(negedge clk);
    enter = 1'b1;
    senha = 8'hA5;
    @(negedge clk);             // E+1
    enter = 1'b0;
    @(negedge clk);             // E+2
    @(negedge clk);             // E+3
    senha = 8'h3C;
    enter = 1'b1;
    @(negedge clk);             // E+4
    enter = 1'b0;
    check("t6_busy", {31'd0, busy}, 32'd1);
    check("t6_addr", {27'd0, mem_addr}, 32'd3);
    clr_n = 1'b0;
    #1;
    check("t6_rst_outs", {busy, granted, denied, locked, mem_addr, match_idx, fail_cnt}, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    attempt(8'h77, lat);
    check("t6_lat", lat, 12);
    check("t6_idx", {27'd0, match_idx}, 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
